// File: rtl/io_bus_bridge_pkg.sv
// Shared types and the I/O decode map for the CPU-to-peripheral bridge.
// Addresses here are word addresses, i.e. bits [15:1] of the byte address.
package io_pkg;

   typedef enum logic [3:0] {
      LEDS      = 4'd0,
      SDRAM_CFG = 4'd1,
      UART      = 4'd2,
      SPI       = 4'd3,
      IRQ_CTL   = 4'd4,
      BIOS_CTL  = 4'd5,
      TIMER     = 4'd6,
      PIC       = 4'd7,
      VGA_REG   = 4'd8,
      PS2_MOUSE = 4'd9,
      PS2_KBD   = 4'd10
   } io_dev_t;

   localparam int NDEV   = 11;
   localparam int ADDR_W = 15;

   typedef logic [ADDR_W-1:0] io_addr_t;

   // A device matches when (addr ^ BASE) & MASK is zero; cleared mask bits are don't-care.
   localparam io_addr_t LEDS_BASE      = 15'h7FFF;
   localparam io_addr_t LEDS_MASK      = 15'h7FFF;
   localparam io_addr_t SDRAM_CFG_BASE = 15'h7FFE;
   localparam io_addr_t SDRAM_CFG_MASK = 15'h7FFF;
   localparam io_addr_t UART_BASE      = 15'h7FFD;
   localparam io_addr_t UART_MASK      = 15'h7FFF;
   localparam io_addr_t SPI_BASE       = 15'h7FF8;
   localparam io_addr_t SPI_MASK       = 15'h7FFE;
   localparam io_addr_t IRQ_CTL_BASE   = 15'h7FFB;
   localparam io_addr_t IRQ_CTL_MASK   = 15'h7FFF;
   localparam io_addr_t BIOS_CTL_BASE  = 15'h7FF6;
   localparam io_addr_t BIOS_CTL_MASK  = 15'h7FFF;
   localparam io_addr_t TIMER_BASE     = 15'h0020;
   localparam io_addr_t TIMER_MASK     = 15'h7FFE;
   localparam io_addr_t PIC_BASE       = 15'h0010;
   localparam io_addr_t PIC_MASK       = 15'h7FFF;
   localparam io_addr_t VGA_REG_BASE   = 15'h01E8;
   localparam io_addr_t VGA_REG_MASK   = 15'h7FF8;
   localparam io_addr_t PS2_MOUSE_BASE = 15'h7FF0;
   localparam io_addr_t PS2_MOUSE_MASK = 15'h7FFF;
   localparam io_addr_t PS2_KBD_BASE   = 15'h0030;
   localparam io_addr_t PS2_KBD_MASK   = 15'h7FFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_DONE = 2'd3
   } io_state_t;

   function automatic io_addr_t dev_base(input io_dev_t dev);
      case (dev)
         LEDS:      return LEDS_BASE;
         SDRAM_CFG: return SDRAM_CFG_BASE;
         UART:      return UART_BASE;
         SPI:       return SPI_BASE;
         IRQ_CTL:   return IRQ_CTL_BASE;
         BIOS_CTL:  return BIOS_CTL_BASE;
         TIMER:     return TIMER_BASE;
         PIC:       return PIC_BASE;
         VGA_REG:   return VGA_REG_BASE;
         PS2_MOUSE: return PS2_MOUSE_BASE;
         PS2_KBD:   return PS2_KBD_BASE;
         default:   return '0;
      endcase
   endfunction

   function automatic io_addr_t dev_mask(input io_dev_t dev);
      case (dev)
         LEDS:      return LEDS_MASK;
         SDRAM_CFG: return SDRAM_CFG_MASK;
         UART:      return UART_MASK;
         SPI:       return SPI_MASK;
         IRQ_CTL:   return IRQ_CTL_MASK;
         BIOS_CTL:  return BIOS_CTL_MASK;
         TIMER:     return TIMER_MASK;
         PIC:       return PIC_MASK;
         VGA_REG:   return VGA_REG_MASK;
         PS2_MOUSE: return PS2_MOUSE_MASK;
         PS2_KBD:   return PS2_KBD_MASK;
         default:   return '1;
      endcase
   endfunction

endpackage

// File: rtl/io_bus_bridge_addr_decoder.sv
// Combinational I/O address decode: word address [15:1] to a one-hot device select.
// 'mapped' is high when any device claims the address.
module io_addr_decoder
   import io_pkg::*;
(
   input  logic [14:0]     addr,
   output logic [NDEV-1:0] dev_hit,
   output logic            mapped
);

   for (genvar g = 0; g < NDEV; g++) begin : g_hit
      localparam io_dev_t DEV = io_dev_t'(g);
      assign dev_hit[g] = ((addr ^ dev_base(DEV)) & dev_mask(DEV)) == '0;
   end

   assign mapped = |dev_hit;

   // The decode map is disjoint by construction; catch any edit that breaks that.
   always_comb begin
      assert ($onehot0(dev_hit));
   end

endmodule

// File: rtl/io_bus_bridge.sv
// Registered I/O-space bridge: latches a core I/O request, drives one-hot chip selects,
// and returns exactly one io_ack beat per request, bounded by a wait timeout.
module io_bus_bridge
   import io_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [15:0] UNMAPPED_DATA  = 16'h0000
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            data_m_access,
   input  logic            d_io,
   input  logic [18:0]     data_m_addr,
   input  logic            data_m_wr_en,
   input  logic [1:0]      data_m_bytesel,
   input  logic [NDEV-1:0] dev_ack,
   input  logic [15:0]     dev_data,
   output logic [NDEV-1:0] dev_cs,
   output logic [14:0]     dev_addr,
   output logic            dev_wr_en,
   output logic [1:0]      dev_bytesel,
   output logic            io_ack,
   output logic [15:0]     io_data,
   output logic            timeout_pulse,
   output logic [7:0]      timeout_count,
   output logic [1:0]      dbg_state
);

   localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

   io_state_t       state;
   logic [15:0]     wait_cnt;
   logic [NDEV-1:0] dec_hit;
   logic            dec_mapped;
   logic            sel_ack;
   logic            addr_unused;

   io_addr_decoder u_decoder (
      .addr    (data_m_addr[14:0]),
      .dev_hit (dec_hit),
      .mapped  (dec_mapped)
   );

   // Only [15:1] of the word address is I/O space.
   assign addr_unused = ^data_m_addr[18:15];
   assign sel_ack     = |(dev_ack & dev_cs);
   assign dbg_state   = state;

   // Handshake: the core raises data_m_access (with d_io) and holds it and the request
   // fields until it sees io_ack for one cycle; it must drop access before the bridge
   // leaves DONE. Devices answer with dev_ack while their dev_cs bit is high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         wait_cnt      <= '0;
         dev_cs        <= '0;
         dev_addr      <= '0;
         dev_wr_en     <= 1'b0;
         dev_bytesel   <= '0;
         io_ack        <= 1'b0;
         io_data       <= '0;
         timeout_pulse <= 1'b0;
         timeout_count <= '0;
      end else begin
         io_ack        <= 1'b0;
         io_data       <= '0;
         timeout_pulse <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (data_m_access && d_io) begin
                  dev_addr    <= data_m_addr[14:0];
                  dev_wr_en   <= data_m_wr_en;
                  dev_bytesel <= data_m_bytesel;
                  if (dec_mapped) begin
                     dev_cs   <= dec_hit;
                     wait_cnt <= '0;
                     state    <= ST_WAIT;
                  end else begin
                     io_ack  <= 1'b1;
                     io_data <= UNMAPPED_DATA;
                     state   <= ST_ACK;
                  end
               end
            end
            ST_WAIT: begin
               // A device ack on the expiry cycle still wins over the timeout.
               if (sel_ack) begin
                  dev_cs  <= '0;
                  io_ack  <= 1'b1;
                  io_data <= dev_data;
                  state   <= ST_ACK;
               end else if (wait_cnt == WAIT_LAST) begin
                  dev_cs        <= '0;
                  io_ack        <= 1'b1;
                  io_data       <= UNMAPPED_DATA;
                  timeout_pulse <= 1'b1;
                  if (timeout_count != 8'hFF) begin
                     timeout_count <= timeout_count + 8'd1;
                  end
                  state <= ST_ACK;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            ST_ACK: begin
               state <= ST_DONE;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_bridge.sv
// Self-checking bench for io_bus_bridge: a transaction-level model predicts chip selects,
// ack timing, read data and timeout accounting for directed and random I/O accesses.
module tb_io_bus_bridge;
   import io_pkg::*;

   localparam int T = 8;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            data_m_access = 1'b0;
   logic            d_io = 1'b0;
   logic [18:0]     data_m_addr = '0;
   logic            data_m_wr_en = 1'b0;
   logic [1:0]      data_m_bytesel = '0;
   logic [NDEV-1:0] dev_ack = '0;
   logic [15:0]     dev_data = '0;
   logic [NDEV-1:0] dev_cs;
   logic [14:0]     dev_addr;
   logic            dev_wr_en;
   logic [1:0]      dev_bytesel;
   logic            io_ack;
   logic [15:0]     io_data;
   logic            timeout_pulse;
   logic [7:0]      timeout_count;
   logic [1:0]      dbg_state;

   int n_tests = 0;
   int n_fail = 0;
   int model_tcount = 0;
   logic [15:0] exp_q[$];

   io_bus_bridge #(.TIMEOUT_CYCLES(T), .UNMAPPED_DATA(16'h0000)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .data_m_access  (data_m_access),
      .d_io           (d_io),
      .data_m_addr    (data_m_addr),
      .data_m_wr_en   (data_m_wr_en),
      .data_m_bytesel (data_m_bytesel),
      .dev_ack        (dev_ack),
      .dev_data       (dev_data),
      .dev_cs         (dev_cs),
      .dev_addr       (dev_addr),
      .dev_wr_en      (dev_wr_en),
      .dev_bytesel    (dev_bytesel),
      .io_ack         (io_ack),
      .io_data        (io_data),
      .timeout_pulse  (timeout_pulse),
      .timeout_count  (timeout_count),
      .dbg_state      (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Decode map written from the byte-address table.
   function automatic int exp_dev(input logic [15:0] a);
      if (a[15:4] == 12'h03D) return int'(VGA_REG);
      case (a)
         16'hFFFE:          return int'(LEDS);
         16'hFFFC:          return int'(SDRAM_CFG);
         16'hFFFA:          return int'(UART);
         16'hFFF0, 16'hFFF2: return int'(SPI);
         16'hFFF6:          return int'(IRQ_CTL);
         16'hFFEC:          return int'(BIOS_CTL);
         16'h0040, 16'h0042: return int'(TIMER);
         16'h0020:          return int'(PIC);
         16'hFFE0:          return int'(PS2_MOUSE);
         16'h0060:          return int'(PS2_KBD);
         default:           return -1;
      endcase
   endfunction

   // One access. d = cycles the device waits after its first selected cycle (0 = acks at
   // once), negative = never acks. lat = clock edges from request until the core samples io_ack.
   task automatic run_access(input logic [15:0] a, input logic wr, input logic [1:0] bsel,
                             input int d, input logic [15:0] rdata, input logic stray,
                             output int lat, output logic [15:0] got);
      int dev, n_wait, ack_k, other;
      bit mapped, by_dev, tmo;
      logic [NDEV-1:0] cs_exp;
      logic [15:0] exp_data, popped;
      dev    = exp_dev(a);
      mapped = (dev >= 0);
      cs_exp = '0;
      if (mapped) cs_exp[dev] = 1'b1;
      other  = mapped ? (dev + 1) % NDEV : 0;
      by_dev = mapped && d >= 0 && d < T;
      tmo    = mapped && !by_dev;
      n_wait = by_dev ? d + 1 : T;
      ack_k  = mapped ? n_wait + 1 : 1;
      exp_data = by_dev ? rdata : 16'h0000;
      exp_q.push_back(exp_data);
      data_m_access  = 1'b1;
      d_io           = 1'b1;
      data_m_addr    = {4'b0, a[15:1]};
      data_m_wr_en   = wr;
      data_m_bytesel = bsel;
      lat = -1;
      got = '0;
      for (int k = 1; k <= T + 4 && lat < 0; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("dev_cs", 32'(dev_cs), 32'((mapped && k <= n_wait) ? cs_exp : '0));
         check("io_ack", 32'(io_ack), 32'(k == ack_k));
         if (k == ack_k && tmo && model_tcount < 255) model_tcount++;
         check("timeout_pulse", 32'(timeout_pulse), 32'(k == ack_k && tmo));
         check("timeout_count", 32'(timeout_count), 32'(model_tcount));
         if (mapped) begin
            check("dev_addr", 32'(dev_addr), 32'(a[15:1]));
            check("dev_wr_en", 32'(dev_wr_en), 32'(wr));
            check("dev_bytesel", 32'(dev_bytesel), 32'(bsel));
         end
         dev_ack  = '0;
         dev_data = '0;
         if (io_ack) begin
            lat = k + 1;
            got = io_data;
            data_m_access = 1'b0;
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 32'(io_data), 32'hFFFF_FFFF);
            end else begin
               popped = exp_q.pop_front();
               check("io_data", 32'(io_data), 32'(popped));
            end
         end else begin
            check("io_data_idle", 32'(io_data), 32'h0);
            if (by_dev && k == d + 1) begin
               dev_ack[dev] = 1'b1;
               dev_data     = rdata;
            end
            if (stray && mapped && k == 1) dev_ack[other] = 1'b1;
         end
      end
      if (lat < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL ack_wait: no io_ack within %0d cycles for addr %h", T + 4, a);
         data_m_access = 1'b0;
         exp_q.delete();
      end
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
         check("io_ack_after", 32'(io_ack), 32'h0);
         check("dev_cs_after", 32'(dev_cs), 32'h0);
      end
   endtask

   logic [15:0] addr_pool[12] = '{16'hFFFE, 16'hFFFC, 16'hFFFA, 16'hFFF0, 16'hFFF2, 16'hFFF6,
                                  16'hFFEC, 16'h0040, 16'h0042, 16'h0020, 16'h03D6, 16'h0060};

   initial begin
      int lat;
      logic [15:0] got;
      logic [15:0] a;
      // Reset state
      #1;
      check("rst_dev_cs", 32'(dev_cs), 32'h0);
      check("rst_io_ack", 32'(io_ack), 32'h0);
      check("rst_io_data", 32'(io_data), 32'h0);
      check("rst_tcount", 32'(timeout_count), 32'h0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // UART read, one-cycle device
      run_access(16'hFFFA, 1'b0, 2'b11, 0, 16'h00A5, 1'b0, lat, got);
      check("uart_latency", 32'(lat), 32'd3);
      check("uart_data", 32'(got), 32'h00A5);

      // TIMER write
      run_access(16'h0042, 1'b1, 2'b01, 0, 16'h0000, 1'b0, lat, got);
      check("timer_dev_addr", 32'(dev_addr), 32'h0021);
      check("timer_wr_en", 32'(dev_wr_en), 32'h1);
      check("timer_bytesel", 32'(dev_bytesel), 32'h1);

      // Unmapped read
      run_access(16'h0300, 1'b0, 2'b11, 0, 16'hBEEF, 1'b0, lat, got);
      check("unmapped_latency", 32'(lat), 32'd2);
      check("unmapped_data", 32'(got), 32'h0);

      // PIC never acks: timeout
      run_access(16'h0020, 1'b0, 2'b11, -1, 16'h0000, 1'b0, lat, got);
      check("timeout_latency", 32'(lat), 32'd10);
      check("timeout_count_1", 32'(timeout_count), 32'h1);

      // Ack on the expiry cycle wins; stray ack ignored
      run_access(16'h0020, 1'b0, 2'b11, T - 1, 16'h5A5A, 1'b1, lat, got);
      check("ackwin_latency", 32'(lat), 32'd10);
      check("ackwin_data", 32'(got), 32'h5A5A);
      check("ackwin_count", 32'(timeout_count), 32'h1);
      run_access(16'hFFFA, 1'b0, 2'b10, 3, 16'h1357, 1'b1, lat, got);
      check("stray_latency", 32'(lat), 32'd6);

      // d_io=0 is never acted on
      data_m_access = 1'b1;
      d_io = 1'b0;
      data_m_addr = 19'h07FFF;
      repeat (5) begin
         @(posedge clk);
         @(negedge clk);
         check("nod_io_ack", 32'(io_ack), 32'h0);
         check("nod_io_cs", 32'(dev_cs), 32'h0);
         check("nod_io_state", 32'(dbg_state), 32'(ST_IDLE));
      end
      data_m_access = 1'b0;

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 65535)) & 16'hFFFE;
         else a = addr_pool[$urandom_range(0, 11)];
         run_access(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, T + 1)) - 1, 16'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 1)), lat, got);
      end

      // Saturate the timeout counter
      for (int i = 0; i < 260; i++) begin
         run_access(16'h0020, 1'b0, 2'b11, -1, 16'h0000, 1'b0, lat, got);
      end
      check("tcount_saturated", 32'(timeout_count), 32'hFF);

      // Asynchronous reset during WAIT
      data_m_access = 1'b1;
      d_io = 1'b1;
      data_m_addr = 19'h00010;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre_reset_cs", 32'(dev_cs), 32'(1 << int'(PIC)));
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_cs", 32'(dev_cs), 32'h0);
      check("async_rst_ack", 32'(io_ack), 32'h0);
      check("async_rst_state", 32'(dbg_state), 32'(ST_IDLE));
      check("async_rst_tcount", 32'(timeout_count), 32'h0);
      model_tcount = 0;
      data_m_access = 1'b0;
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      run_access(16'hFFFE, 1'b0, 2'b11, 1, 16'h1234, 1'b0, lat, got);
      check("post_rst_latency", 32'(lat), 32'd4);
      check("post_rst_data", 32'(got), 32'h1234);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
